// File: rtl/clk_reset_sequencer.sv
// Clock/reset manager: qualifies PLL lock, stretches reset, releases per-domain resets in a
// staggered order, and provides a clock-enable strobe plus a heartbeat counter bit.
module clk_reset_sequencer #(
  parameter int RST_CYCLES     = 65536,
  parameter int LOCK_FILTER    = 16,
  parameter int NUM_DOMAINS    = 2,
  parameter int STAGGER_CYCLES = 256,
  parameter int DIV_W          = 8,
  parameter int HB_BIT         = 23
) (
  input  logic                   clk_in,
  input  logic                   resetn_in,
  input  logic                   lock_in,
  input  logic                   force_reset_in,
  input  logic [DIV_W-1:0]       div_in,
  output logic [NUM_DOMAINS-1:0] rstn_out,
  output logic                   ready_out,
  output logic                   ce_out,
  output logic [7:0]             relock_count_out,
  output logic                   heartbeat_out
);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] STRETCH   = 2'd1;
  localparam logic [1:0] RELEASE   = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  localparam int FILT_W  = (LOCK_FILTER < 2) ? 1 : $clog2(LOCK_FILTER);
  localparam int STR_W   = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
  localparam int STG_MAX = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int STG_W   = (STG_MAX < 2) ? 1 : $clog2(STG_MAX + 1);

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [STR_W-1:0]  STR_LAST  = STR_W'(RST_CYCLES - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [2:0]             sync_r;
  logic                   lock_s;
  logic [1:0]             state_r;
  logic [FILT_W-1:0]      filt_cnt_r;
  logic [STR_W-1:0]       str_cnt_r;
  logic [STG_W-1:0]       stag_cnt_r;
  logic [STG_W-1:0]       stag_next_s;
  logic [NUM_DOMAINS-1:0] rel_mask_s;
  logic [NUM_DOMAINS-1:0] rstn_r;
  logic                   ready_r;
  logic                   ce_r;
  logic [DIV_W-1:0]       div_cnt_r;
  logic [DIV_W-1:0]       period_r;
  logic [DIV_W-1:0]       period_eff_s;
  logic                   div_hit_s;
  logic [7:0]             relock_r;
  logic [HB_BIT:0]        hb_cnt_r;

  assign lock_s = sync_r[2];

  // Lock synchroniser; a software reset also flushes it so a restart looks like a fresh lock acquisition.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      sync_r <= 3'b000;
    end else if (force_reset_in) begin
      sync_r <= 3'b000;
    end else begin
      sync_r <= {sync_r[1:0], lock_in};
    end
  end

  // Release mask: bit k is set once the stagger count reaches k*STAGGER_CYCLES.
  always_comb begin
    rel_mask_s  = {NUM_DOMAINS{1'b0}};
    stag_next_s = (state_r == STRETCH) ? {STG_W{1'b0}} : stag_cnt_r + STG_W'(1);
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      rel_mask_s[k] = (int'(stag_next_s) >= k * STAGGER_CYCLES);
    end
  end

  // Divider terminal count; 0 and 1 both mean a strobe every cycle.
  always_comb begin
    period_eff_s = (period_r == {DIV_W{1'b0}}) ? DIV_W'(1) : period_r;
    div_hit_s    = (div_cnt_r >= period_eff_s - DIV_W'(1));
  end

  // Sequencer FSM with its counters, reset outputs, clock enable and lock-loss counter.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      state_r    <= WAIT_LOCK;
      filt_cnt_r <= {FILT_W{1'b0}};
      str_cnt_r  <= {STR_W{1'b0}};
      stag_cnt_r <= {STG_W{1'b0}};
      rstn_r     <= {NUM_DOMAINS{1'b0}};
      ready_r    <= 1'b0;
      ce_r       <= 1'b0;
      div_cnt_r  <= {DIV_W{1'b0}};
      period_r   <= {DIV_W{1'b0}};
      relock_r   <= 8'd0;
    end else if (force_reset_in) begin
      state_r    <= WAIT_LOCK;
      filt_cnt_r <= {FILT_W{1'b0}};
      str_cnt_r  <= {STR_W{1'b0}};
      stag_cnt_r <= {STG_W{1'b0}};
      rstn_r     <= {NUM_DOMAINS{1'b0}};
      ready_r    <= 1'b0;
      ce_r       <= 1'b0;
      div_cnt_r  <= {DIV_W{1'b0}};
      period_r   <= {DIV_W{1'b0}};
      // A coincident lock loss in RUN is still counted, exactly once.
      if (state_r == RUN && !lock_s) begin
        relock_r <= sat_inc(relock_r);
      end else begin
        relock_r <= relock_r;
      end
    end else begin
      case (state_r)
        WAIT_LOCK: begin
          rstn_r  <= {NUM_DOMAINS{1'b0}};
          ready_r <= 1'b0;
          ce_r    <= 1'b0;
          if (!lock_s) begin
            filt_cnt_r <= {FILT_W{1'b0}};
          end else if (filt_cnt_r == FILT_LAST) begin
            filt_cnt_r <= {FILT_W{1'b0}};
            str_cnt_r  <= {STR_W{1'b0}};
            state_r    <= STRETCH;
          end else begin
            filt_cnt_r <= filt_cnt_r + FILT_W'(1);
          end
        end
        STRETCH: begin
          if (!lock_s) begin
            str_cnt_r <= {STR_W{1'b0}};
            state_r   <= WAIT_LOCK;
          end else if (str_cnt_r == STR_LAST) begin
            str_cnt_r  <= {STR_W{1'b0}};
            stag_cnt_r <= {STG_W{1'b0}};
            rstn_r     <= rel_mask_s;
            if (&rel_mask_s) begin
              state_r   <= RUN;
              ready_r   <= 1'b1;
              ce_r      <= 1'b1;
              div_cnt_r <= {DIV_W{1'b0}};
              period_r  <= div_in;
            end else begin
              state_r <= RELEASE;
            end
          end else begin
            str_cnt_r <= str_cnt_r + STR_W'(1);
          end
        end
        RELEASE: begin
          if (!lock_s) begin
            stag_cnt_r <= {STG_W{1'b0}};
            rstn_r     <= {NUM_DOMAINS{1'b0}};
            state_r    <= WAIT_LOCK;
          end else begin
            stag_cnt_r <= stag_next_s;
            rstn_r     <= rstn_r | rel_mask_s;
            if (&rel_mask_s) begin
              state_r   <= RUN;
              ready_r   <= 1'b1;
              ce_r      <= 1'b1;
              div_cnt_r <= {DIV_W{1'b0}};
              period_r  <= div_in;
            end else begin
              state_r <= RELEASE;
            end
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_r    <= WAIT_LOCK;
            stag_cnt_r <= {STG_W{1'b0}};
            rstn_r     <= {NUM_DOMAINS{1'b0}};
            ready_r    <= 1'b0;
            ce_r       <= 1'b0;
            div_cnt_r  <= {DIV_W{1'b0}};
            period_r   <= {DIV_W{1'b0}};
            relock_r   <= sat_inc(relock_r);
          end else if (div_hit_s) begin
            ce_r      <= 1'b1;
            div_cnt_r <= {DIV_W{1'b0}};
            period_r  <= div_in;
          end else begin
            ce_r      <= 1'b0;
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end
        default: begin
          state_r    <= WAIT_LOCK;
          filt_cnt_r <= {FILT_W{1'b0}};
          str_cnt_r  <= {STR_W{1'b0}};
          stag_cnt_r <= {STG_W{1'b0}};
          rstn_r     <= {NUM_DOMAINS{1'b0}};
          ready_r    <= 1'b0;
          ce_r       <= 1'b0;
          div_cnt_r  <= {DIV_W{1'b0}};
          period_r   <= {DIV_W{1'b0}};
        end
      endcase
    end
  end

  // Free-running heartbeat counter, cleared only by the hardware reset.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      hb_cnt_r <= {(HB_BIT + 1){1'b0}};
    end else begin
      hb_cnt_r <= hb_cnt_r + (HB_BIT + 1)'(1);
    end
  end

  assign rstn_out         = rstn_r;
  assign ready_out        = ready_r;
  assign ce_out           = ce_r;
  assign relock_count_out = relock_r;
  assign heartbeat_out    = hb_cnt_r[HB_BIT];

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Scoreboard bench for clk_reset_sequencer: expectations are queued per clock edge as stimulus
// is applied and compared when that edge arrives.
module tb_clk_reset_sequencer;

  localparam int RST_CYCLES     = 16;
  localparam int LOCK_FILTER    = 4;
  localparam int NUM_DOMAINS    = 3;
  localparam int STAGGER_CYCLES = 8;
  localparam int DIV_W          = 8;
  localparam int HB_BIT         = 4;

  logic             clk_in = 1'b0;
  logic             resetn_in = 1'b0;
  logic             lock_in = 1'b0;
  logic             force_reset_in = 1'b0;
  logic [DIV_W-1:0] div_in = 8'd5;
  logic [2:0]       rstn_out;
  logic             ready_out;
  logic             ce_out;
  logic [7:0]       relock_count_out;
  logic             heartbeat_out;

  clk_reset_sequencer #(
    .RST_CYCLES(RST_CYCLES), .LOCK_FILTER(LOCK_FILTER), .NUM_DOMAINS(NUM_DOMAINS),
    .STAGGER_CYCLES(STAGGER_CYCLES), .DIV_W(DIV_W), .HB_BIT(HB_BIT)
  ) dut (
    .clk_in(clk_in), .resetn_in(resetn_in), .lock_in(lock_in),
    .force_reset_in(force_reset_in), .div_in(div_in), .rstn_out(rstn_out),
    .ready_out(ready_out), .ce_out(ce_out), .relock_count_out(relock_count_out),
    .heartbeat_out(heartbeat_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] rstn;
    logic       ready;
    logic       ce;
    logic [7:0] relock;
  } exp_t;

  exp_t sb_q[$];
  int   cyc_n = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic push_exp(input int c, input string nm, input logic [2:0] r, input logic rdy,
                          input logic ce, input logic [7:0] rl);
    exp_t e;
    e.cyc = c; e.name = nm; e.rstn = r; e.ready = rdy; e.ce = ce; e.relock = rl;
    sb_q.push_back(e);
  endtask

  // One clock edge; outputs are sampled 1 time unit after it and matched against due entries.
  task automatic tick();
    exp_t e;
    @(posedge clk_in);
    cyc_n++;
    #1;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_n) begin
      e = sb_q.pop_front();
      vectors++;
      if (e.cyc != cyc_n || rstn_out !== e.rstn || ready_out !== e.ready ||
          ce_out !== e.ce || relock_count_out !== e.relock) begin
        miscompares++;
        $display("FAIL %s cyc=%0d(due %0d) got rstn=%b ready=%b ce=%b relock=%0d exp rstn=%b ready=%b ce=%b relock=%0d",
                 e.name, cyc_n, e.cyc, rstn_out, ready_out, ce_out, relock_count_out,
                 e.rstn, e.ready, e.ce, e.relock);
      end
    end
  endtask

  task automatic run_to(input int c);
    while (cyc_n < c) tick();
  endtask

  // Returns the cycle number of edge 0 (first edge after reset release, lock held high).
  task automatic test_reset(output int base);
    resetn_in = 1'b0;
    lock_in = 1'b1;
    force_reset_in = 1'b0;
    repeat (3) tick();
    vectors++;
    if (rstn_out !== 3'b000 || ready_out !== 1'b0 || ce_out !== 1'b0 ||
        relock_count_out !== 8'd0 || heartbeat_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got rstn=%b ready=%b ce=%b relock=%0d hb=%b exp all zero",
               rstn_out, ready_out, ce_out, relock_count_out, heartbeat_out);
    end
    resetn_in = 1'b1;
    base = cyc_n + 1;
  endtask

  task automatic test_startup(input int base);
    push_exp(base + 21, "pre_rel0", 3'b000, 1'b0, 1'b0, 8'd0);
    push_exp(base + 22, "rel0",     3'b001, 1'b0, 1'b0, 8'd0);
    push_exp(base + 29, "pre_rel1", 3'b001, 1'b0, 1'b0, 8'd0);
    push_exp(base + 30, "rel1",     3'b011, 1'b0, 1'b0, 8'd0);
    push_exp(base + 37, "pre_rel2", 3'b011, 1'b0, 1'b0, 8'd0);
    push_exp(base + 38, "rel2_rdy", 3'b111, 1'b1, 1'b1, 8'd0);
    run_to(base + 14);
    vectors++;
    if (heartbeat_out !== 1'b0) begin
      miscompares++;
      $display("FAIL heartbeat_lo got %b exp 0", heartbeat_out);
    end
    run_to(base + 15);
    vectors++;
    if (heartbeat_out !== 1'b1) begin
      miscompares++;
      $display("FAIL heartbeat_hi got %b exp 1", heartbeat_out);
    end
    run_to(base + 38);
  endtask

  // div_in=5 latched on the first strobe at base+38; switched to 0 between strobes.
  task automatic test_clock_enable(input int base);
    for (int c = base + 39; c <= base + 50; c++) begin
      push_exp(c, "ce_div5", 3'b111, 1'b1, ((c - base - 38) % 5 == 0), 8'd0);
    end
    run_to(base + 50);
    div_in = 8'd0;
    for (int c = base + 51; c <= base + 58; c++) begin
      push_exp(c, "ce_div0", 3'b111, 1'b1, (c >= base + 53), 8'd0);
    end
    run_to(base + 58);
  endtask

  task automatic test_lock_glitch();
    int base;
    int b2;
    test_reset(base);
    run_to(base + 3);
    lock_in = 1'b0;
    tick();
    lock_in = 1'b1;
    b2 = base + 5;
    push_exp(b2 + 21, "glitch_pre", 3'b000, 1'b0, 1'b0, 8'd0);
    push_exp(b2 + 22, "glitch_rel", 3'b001, 1'b0, 1'b0, 8'd0);
    push_exp(b2 + 38, "glitch_rdy", 3'b111, 1'b1, 1'b1, 8'd0);
    run_to(b2 + 38);
  endtask

  task automatic test_lock_loss();
    int d0;
    int b;
    lock_in = 1'b0;
    d0 = cyc_n + 1;
    push_exp(d0 + 2, "loss_hold", 3'b111, 1'b1, 1'b1, 8'd0);
    push_exp(d0 + 3, "loss_drop", 3'b000, 1'b0, 1'b0, 8'd1);
    run_to(d0 + 4);
    lock_in = 1'b1;
    b = cyc_n + 1;
    push_exp(b + 21, "reseq_pre", 3'b000, 1'b0, 1'b0, 8'd1);
    push_exp(b + 22, "reseq_rel0", 3'b001, 1'b0, 1'b0, 8'd1);
    push_exp(b + 30, "reseq_rel1", 3'b011, 1'b0, 1'b0, 8'd1);
    push_exp(b + 38, "reseq_rdy", 3'b111, 1'b1, 1'b1, 8'd1);
    run_to(b + 38);
  endtask

  task automatic test_force();
    int f0;
    int b;
    force_reset_in = 1'b1;
    f0 = cyc_n + 1;
    push_exp(f0, "force_drop", 3'b000, 1'b0, 1'b0, 8'd1);
    push_exp(f0 + 5, "force_held", 3'b000, 1'b0, 1'b0, 8'd1);
    run_to(f0 + 9);
    force_reset_in = 1'b0;
    b = f0 + 10;
    push_exp(b + 21, "force_pre", 3'b000, 1'b0, 1'b0, 8'd1);
    push_exp(b + 22, "force_rel0", 3'b001, 1'b0, 1'b0, 8'd1);
    push_exp(b + 38, "force_rdy", 3'b111, 1'b1, 1'b1, 8'd1);
    run_to(b + 38);
  endtask

  task automatic test_relock_saturate();
    int d0;
    int b;
    logic [7:0] exp_rl;
    for (int i = 2; i <= 300; i++) begin
      exp_rl = (i > 255) ? 8'd255 : 8'(i);
      lock_in = 1'b0;
      d0 = cyc_n + 1;
      push_exp(d0 + 3, "sat_drop", 3'b000, 1'b0, 1'b0, exp_rl);
      run_to(d0 + 4);
      lock_in = 1'b1;
      b = cyc_n + 1;
      push_exp(b + 38, "sat_rdy", 3'b111, 1'b1, 1'b1, exp_rl);
      run_to(b + 38);
    end
  endtask

  task automatic test_async_reset();
    int b;
    lock_in = 1'b0;
    repeat (5) tick();
    lock_in = 1'b1;
    b = cyc_n + 1;
    push_exp(b + 22, "mid_rel0", 3'b001, 1'b0, 1'b0, 8'd255);
    run_to(b + 25);
    #2;
    resetn_in = 1'b0;
    #1;
    vectors++;
    if (rstn_out !== 3'b000 || ready_out !== 1'b0 || ce_out !== 1'b0 ||
        relock_count_out !== 8'd0 || heartbeat_out !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got rstn=%b ready=%b ce=%b relock=%0d hb=%b exp all zero",
               rstn_out, ready_out, ce_out, relock_count_out, heartbeat_out);
    end
    repeat (2) tick();
    resetn_in = 1'b1;
    b = cyc_n + 1;
    push_exp(b + 21, "restart_pre", 3'b000, 1'b0, 1'b0, 8'd0);
    push_exp(b + 22, "restart_rel0", 3'b001, 1'b0, 1'b0, 8'd0);
    push_exp(b + 38, "restart_rdy", 3'b111, 1'b1, 1'b1, 8'd0);
    run_to(b + 38);
  endtask

  initial begin
    int base;
    test_reset(base);
    test_startup(base);
    test_clock_enable(base);
    test_lock_glitch();
    test_lock_loss();
    test_force();
    test_relock_saturate();
    test_async_reset();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d exp completion before time limit", cyc_n);
    $fatal(1, "watchdog expired");
  end

endmodule
